// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared state encoding, segment codes and double-dabble step for the digit scanner
package seg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_DIGITS = 5;

    // Segment order {a,b,c,d,e,f,g,dp}, active low, dp always off
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_T     = 8'hE1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // One iteration on {bcd[19:0], bin[15:0]}: correct nibbles >= 5, then shift left
    function automatic logic [35:0] dabble_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (t[16+4*i +: 4] >= 4'd5)
                t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit binary to 5-digit BCD converter, one iteration per cycle
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] din,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] work;
    logic [3:0]  iter;
    logic        running;

    always_ff @(posedge clock) begin
        if (reset) begin
            work    <= '0;
            iter    <= '0;
            running <= 1'b0;
        end else if (start) begin
            work    <= {20'd0, din};
            iter    <= '0;
            running <= 1'b1;
        end else if (running) begin
            work <= dabble_step(work);
            iter <= iter + 4'd1;
            if (iter == 4'd15)
                running <= 1'b0;
        end
    end

    // High during the cycle whose closing edge performs the 16th iteration,
    // so the caller can leave its shift state on that same edge.
    assign done = running && (iter == 4'd15);
    assign bcd  = work[35:16];

endmodule

// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - 8-digit multiplexed display of decimal word, source letter and prog; LEADING_ZERO_BLANK_EN blanks leading zeros
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int REFRESH_COUNT = 100000
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        data_valid,
    input  logic [15:0] data_in,
    input  logic        module_sel,
    input  logic [2:0]  prog,
    output logic        busy,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp
);

    localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam int SW = $clog2(NUM_DIGITS);

    state_t      state;
    logic        pending_v;
    logic [15:0] pending_word;
    logic [19:0] disp_bcd;

    logic        conv_start;
    logic [15:0] conv_din;
    logic        conv_done;
    logic [19:0] conv_bcd;

    logic [CW-1:0] refresh_cnt;
    logic [SW-1:0] scan_idx;

    logic [BCD_DIGITS-1:0] shown;
    logic [7:0]            cur_code;

    // A pending word always takes priority over a fresh strobe in IDLE
    assign conv_start = (state == ST_IDLE) && (pending_v || data_valid);
    assign conv_din   = pending_v ? pending_word : data_in;
    assign busy       = (state != ST_IDLE) || pending_v;

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .din   (conv_din),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending_v    <= 1'b0;
            pending_word <= '0;
            disp_bcd     <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (conv_start) state <= ST_SHIFT;
                ST_SHIFT:  if (conv_done) state <= ST_COMMIT;
                ST_COMMIT: begin
                    disp_bcd <= conv_bcd;
                    state    <= ST_IDLE;
                end
                default:   state <= ST_IDLE;
            endcase

            if (data_valid) begin
                pending_word <= data_in;
                pending_v    <= !((state == ST_IDLE) && !pending_v);
            end else if ((state == ST_IDLE) && pending_v) begin
                pending_v <= 1'b0;
            end
        end
    end

    always_comb begin
        shown = '1;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
                seen     = seen || (disp_bcd[4*i +: 4] != 4'd0);
                shown[i] = seen;
            end
        end
`endif
    end

    always_comb begin
        cur_code = SEG_BLANK;
        case (scan_idx)
            3'd0: cur_code = seg_code(disp_bcd[3:0]);
            3'd1: cur_code = shown[1] ? seg_code(disp_bcd[7:4])   : SEG_BLANK;
            3'd2: cur_code = shown[2] ? seg_code(disp_bcd[11:8])  : SEG_BLANK;
            3'd3: cur_code = shown[3] ? seg_code(disp_bcd[15:12]) : SEG_BLANK;
            3'd4: cur_code = shown[4] ? seg_code(disp_bcd[19:16]) : SEG_BLANK;
            3'd6: cur_code = module_sel ? SEG_T : SEG_F;
            3'd7: cur_code = seg_code({1'b0, prog});
            default: cur_code = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            an          <= 8'hFF;
            dec_ddp     <= 8'hFF;
        end else begin
            if (refresh_cnt == CW'(REFRESH_COUNT - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + SW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
            an      <= ~(NUM_DIGITS'(1) << scan_idx);
            dec_ddp <= cur_code;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - directed table-driven bench for seg_display_scan
module tb_seg_display_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        data_valid;
    logic [15:0] data_in;
    logic        module_sel;
    logic [2:0]  prog;
    logic        busy;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0]     value;
        logic            msel;
        logic [2:0]      prg;
        logic [7:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    seg_display_scan #(.REFRESH_COUNT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_valid (data_valid),
        .data_in    (data_in),
        .module_sel (module_sel),
        .prog       (prog),
        .busy       (busy),
        .an         (an),
        .dec_ddp    (dec_ddp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Digits 4..1 that are leading zeros go blank when the macro is set
    function automatic logic [7:0][7:0] lz(input logic [7:0][7:0] e);
        logic [7:0][7:0] r;
        r = e;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 4; i >= 1; i--) begin
            if (r[i] != 8'h03) break;
            r[i] = 8'hFF;
        end
`endif
        return r;
    endfunction

    task automatic capture(input int idx, output logic [7:0] code, output bit ok);
        logic [7:0] mask;
        mask = ~(8'b1 << idx);
        ok   = 1'b0;
        code = 8'hxx;
        for (int n = 0; n < 80; n++) begin
            @(negedge clock);
            if (an == mask) begin
                code = dec_ddp;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_digits(input string tag, input logic [7:0][7:0] e);
        logic [7:0] code;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            capture(i, code, ok);
            if (!ok)
                check($sformatf("%s_d%0d_timeout", tag, i), 32'(ok), 32'd1);
            else
                check($sformatf("%s_d%0d", tag, i), 32'(code), 32'(e[i]));
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic send(input logic [15:0] w);
        @(negedge clock);
        data_in    = w;
        data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]      m;
        logic [7:0][7:0] e;
        logic [7:0]      c65535 [5];
        bit              seen200;

        vecs[0] = '{16'd12345, 1'b0, 3'd0, {8'h03, 8'h71, 8'hFF, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49}};
        vecs[1] = '{16'd65535, 1'b1, 3'd5, {8'h49, 8'hE1, 8'hFF, 8'h41, 8'h49, 8'h49, 8'h0D, 8'h49}};
        vecs[2] = '{16'd7,     1'b0, 3'd7, {8'h1F, 8'h71, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h1F}};
        vecs[3] = '{16'd0,     1'b1, 3'd2, {8'h25, 8'hE1, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03}};
        vecs[4] = '{16'd9080,  1'b0, 3'd1, {8'h9F, 8'h71, 8'hFF, 8'h03, 8'h09, 8'h03, 8'h01, 8'h03}};
        vecs[5] = '{16'd40006, 1'b1, 3'd6, {8'h41, 8'hE1, 8'hFF, 8'h99, 8'h03, 8'h03, 8'h03, 8'h41}};
        c65535 = '{8'h49, 8'h0D, 8'h49, 8'h49, 8'h41};

        reset = 1'b1; data_valid = 1'b0; data_in = '0; module_sel = 1'b0; prog = 3'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_dec", 32'(dec_ddp), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Refresh of 4 cycles per digit, wrapping 7 -> 0
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            m = ~(8'b1 << (((n - 1) / 4) % 8));
            check($sformatf("scan_e%0d", n), 32'(an), 32'(m));
            if (n == 1) check("first_dec", 32'(dec_ddp), 32'h03);
        end

        // busy covers edges 0..16 of a single conversion
        @(negedge clock);
        data_in = 16'd12345; data_valid = 1'b1;
        @(negedge clock);
        data_valid = 1'b0;
        check("busy_e0", 32'(busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check($sformatf("busy_e%0d", k), 32'(busy), 32'd1);
        end
        @(negedge clock);
        check("busy_e17", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            module_sel = vecs[v].msel;
            prog       = vecs[v].prg;
            send(vecs[v].value);
            wait_idle($sformatf("v%0d", v));
            repeat (2) @(negedge clock);
            check_digits($sformatf("v%0d", v), lz(vecs[v].exp));
        end

        // 65535 then 7 on consecutive edges
        module_sel = 1'b0; prog = 3'd3;
        @(negedge clock);
        data_in = 16'd65535; data_valid = 1'b1;
        for (int k = 0; k <= 35; k++) begin
            @(negedge clock);
            if (k == 0) data_in = 16'd7;
            if (k == 1) data_valid = 1'b0;
            check($sformatf("b2b_busy_e%0d", k), 32'(busy), (k < 35) ? 32'd1 : 32'd0);
            if (k >= 19 && k <= 34) begin
                for (int d = 0; d < 5; d++) begin
                    m = ~(8'b1 << d);
                    if (an == m) check($sformatf("b2b_65535_e%0d_d%0d", k, d), 32'(dec_ddp), 32'(c65535[d]));
                end
            end
        end
        repeat (2) @(negedge clock);
        check_digits("b2b_7", lz({8'h0D, 8'h71, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h1F}));

        // Three strobes during one conversion: only the last survives
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        module_sel = 1'b1; prog = 3'd4;
        send(16'd100);
        @(negedge clock);
        send(16'd200);
        @(negedge clock);
        send(16'd300);
        seen200 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (an == 8'hFB && dec_ddp == 8'h25) seen200 = 1'b1;
        end
        check("drop_200", 32'(seen200), 32'd0);
        check("three_busy", 32'(busy), 32'd0);
        check_digits("three_300", lz({8'h99, 8'hE1, 8'hFF, 8'h03, 8'h03, 8'h0D, 8'h03, 8'h03}));

        // Reset in the middle of a conversion
        module_sel = 1'b1; prog = 3'd5;
        send(16'd12345);
        repeat (4) @(negedge clock);
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_rst_an", 32'(an), 32'hFF);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("mid_busy_post", 32'(busy), 32'd0);
        e = {8'h49, 8'hE1, 8'hFF, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        check_digits("mid_zero", lz(e));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
